// File: rtl/button_event_arbiter.sv
// -----------------------------------------------------------------------------
// button_event_arbiter
//
// Purpose:
//   Collects single-cycle press pulses from N_BTN debounced button blocks and
//   keeps one pending request per button. The requests are presented to a
//   consumer one at a time over a valid/ready handshake. A press is never lost
//   while that button's request is still waiting. A press that arrives while
//   its button is already waiting and is not being taken this cycle is
//   dropped, and overflow pulses for one cycle.
//
// Ports:
//   clk        in   1       system clock; all logic on the rising edge
//   rst_a_p    in   1       asynchronous, active-high reset
//   pulse_in   in   N_BTN   one-cycle press pulses; bit i = button i
//   evt_valid  out  1       an event is presented on evt_id
//   evt_ready  in   1       consumer takes the event when evt_valid && evt_ready
//   evt_id     out  IDX_W   index of the button whose event is presented
//   pending    out  N_BTN   registered pending-request vector
//   overflow   out  1       one-cycle pulse: a press was dropped
//
// Parameters:
//   N_BTN  number of buttons (2..16)
//   IDX_W  width of evt_id; 2**IDX_W must be >= N_BTN
//
// Configuration macro:
//   BUTTON_ARB_FIXED_PRIO_EN
//     defined   : fixed priority; the lowest pending index always wins.
//     undefined : round robin from a rotating pointer (default build).
// -----------------------------------------------------------------------------
module button_event_arbiter #(
    parameter int N_BTN = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst_a_p,
    input  logic [N_BTN-1:0] pulse_in,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [IDX_W-1:0] evt_id,
    output logic [N_BTN-1:0] pending,
    output logic             overflow
);

    // The output register is a one-entry slot.
    // EMPTY: nothing is presented. FULL: evt_id is presented.
    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_e;

    state_e             state_q,    state_d;
    logic [IDX_W-1:0]   evt_id_q,   evt_id_d;
    logic [N_BTN-1:0]   pending_q,  pending_d;
    logic               overflow_q, overflow_d;

    logic [IDX_W-1:0]   grant;
    logic               load_en;
    logic [N_BTN-1:0]   clr_mask;

`ifndef BUTTON_ARB_FIXED_PRIO_EN
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
`endif

    // -------------------------------------------------------------------------
    // Grant selection. Only the registered pending vector is used, so a new
    // press always spends one cycle in pending before it can be granted.
    // -------------------------------------------------------------------------
`ifdef BUTTON_ARB_FIXED_PRIO_EN
    always_comb begin
        grant = '0;
        // The scan runs downward, so the lowest set index is assigned last.
        for (int i = N_BTN - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                grant = IDX_W'(i);
            end
        end
    end
`else
    always_comb begin
        int   idx;
        logic found;
        grant = '0;
        found = 1'b0;
        // Search upward from rr_ptr and wrap from N_BTN-1 back to 0.
        // The first pending index found wins.
        for (int k = 0; k < N_BTN; k++) begin
            idx = int'(rr_ptr_q) + k;
            if (idx >= N_BTN) begin
                idx = idx - N_BTN;
            end
            if (!found && pending_q[idx]) begin
                grant = IDX_W'(idx);
                found = 1'b1;
            end
        end
    end
`endif

    // The slot can be refilled when it is empty, or when the current event is
    // accepted this same cycle. Accept and refill on one edge give one event
    // per cycle with no bubble.
    assign load_en  = ((state_q == ST_EMPTY) || evt_ready) && (|pending_q);
    assign clr_mask = load_en ? ({{(N_BTN-1){1'b0}}, 1'b1} << grant) : '0;

    // -------------------------------------------------------------------------
    // Pending and overflow next state. A press on the same edge that its
    // button is transferred re-arms the bit and is not counted as a drop.
    // -------------------------------------------------------------------------
    always_comb begin
        pending_d  = (pending_q & ~clr_mask) | pulse_in;
        overflow_d = |(pulse_in & pending_q & ~clr_mask);
    end

    // -------------------------------------------------------------------------
    // Output slot FSM: next state, evt_id and round-robin pointer.
    // -------------------------------------------------------------------------
    always_comb begin
        // NOTE: every signal this block writes gets a default first. A path
        // that leaves a signal unassigned would infer a latch.
        state_d  = state_q;
        evt_id_d = evt_id_q;
`ifndef BUTTON_ARB_FIXED_PRIO_EN
        rr_ptr_d = rr_ptr_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                // evt_ready is ignored here. Only pending requests fill the slot.
                if (load_en) begin
                    state_d = ST_FULL;
                end
            end
            ST_FULL: begin
                // While stalled, load_en is 0, so evt_id and valid stay put.
                if (load_en) begin
                    state_d = ST_FULL;
                end else if (evt_ready) begin
                    state_d = ST_EMPTY;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load_en) begin
            evt_id_d = grant;
`ifndef BUTTON_ARB_FIXED_PRIO_EN
            rr_ptr_d = (grant == IDX_W'(N_BTN - 1)) ? '0 : grant + 1'b1;
`endif
        end
    end

    // -------------------------------------------------------------------------
    // State registers. Reset discards all requests and any presented event.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only. All registers
    // then update together from the values seen before the edge.
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            state_q    <= ST_EMPTY;
            evt_id_q   <= '0;
            pending_q  <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            evt_id_q   <= evt_id_d;
            pending_q  <= pending_d;
            overflow_q <= overflow_d;
        end
    end

`ifndef BUTTON_ARB_FIXED_PRIO_EN
    always_ff @(posedge clk or posedge rst_a_p) begin
        if (rst_a_p) begin
            rr_ptr_q <= '0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end
`endif

    assign evt_valid = (state_q == ST_FULL);
    assign evt_id    = evt_id_q;
    assign pending   = pending_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_arbiter.sv
// -----------------------------------------------------------------------------
// tb_button_event_arbiter
//
// Self-checking bench for button_event_arbiter with N_BTN=4 and IDX_W=2.
//
// Structure:
//   - A reference model tracks the set of waiting buttons, the presented
//     event and the arbitration pointer, using plain integer arithmetic.
//   - Directed scenarios: reset, single press, round robin, backpressure,
//     overflow, and two presses 200 ns apart.
//   - A randomized run follows the directed scenarios.
//   - Inputs change 1 ns after a rising edge. Outputs are sampled at the same
//     point, well away from the next edge.
// -----------------------------------------------------------------------------
module tb_button_event_arbiter;

    localparam int N = 4;
    localparam int W = 2;

    logic         clk = 1'b0;
    logic         rst_a_p;
    logic [N-1:0] pulse_in;
    logic         evt_valid;
    logic         evt_ready;
    logic [W-1:0] evt_id;
    logic [N-1:0] pending;
    logic         overflow;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    bit [N-1:0] m_pend;
    bit         m_valid;
    int         m_id;
    int         m_ptr;
    bit         m_ovf;

    always #10 clk = ~clk;

    button_event_arbiter #(.N_BTN(N), .IDX_W(W)) dut (
        .clk       (clk),
        .rst_a_p   (rst_a_p),
        .pulse_in  (pulse_in),
        .evt_valid (evt_valid),
        .evt_ready (evt_ready),
        .evt_id    (evt_id),
        .pending   (pending),
        .overflow  (overflow)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    // Which waiting button the consumer should see next.
    function automatic int pick_grant();
`ifdef BUTTON_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) begin
            if (m_pend[i]) return i;
        end
`else
        for (int k = 0; k < N; k++) begin
            if (m_pend[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_pend  = '0;
        m_valid = 1'b0;
        m_id    = 0;
        m_ptr   = 0;
        m_ovf   = 1'b0;
    endtask

    task automatic model_step(input bit [N-1:0] p, input bit r);
        bit         take;
        int         g;
        bit [N-1:0] taken;
        taken = '0;
        g     = 0;
        take  = (!m_valid || r) && (m_pend != 0);
        if (take) begin
            g        = pick_grant();
            taken[g] = 1'b1;
        end
        m_ovf  = |(p & m_pend & ~taken);
        m_pend = (m_pend & ~taken) | p;
        if (take) begin
            m_valid = 1'b1;
            m_id    = g;
            m_ptr   = (g + 1) % N;
        end else if (m_valid && r) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".pending"},  32'(pending),   32'(m_pend));
        check({tag, ".valid"},    32'(evt_valid), 32'(m_valid));
        check({tag, ".id"},       32'(evt_id),    32'(m_id));
        check({tag, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    // One clock: apply inputs, take the edge, advance the model, compare.
    task automatic step(input logic [N-1:0] p, input logic r, input string tag);
        pulse_in  = p;
        evt_ready = r;
        @(posedge clk);
        model_step(p, r);
        #1;
        compare_all(tag);
    endtask

    // Asynchronous reset, asserted mid-cycle and checked before any edge.
    task automatic do_reset(input string tag);
        pulse_in  = '0;
        evt_ready = 1'b0;
        rst_a_p   = 1'b1;
        #1;
        model_reset();
        compare_all(tag);
        #3;
        rst_a_p = 1'b0;
    endtask

    initial begin
        int          ev_q[$];
        bit          ovf_seen;
        logic [N-1:0] rp;

        rst_a_p   = 1'b0;
        pulse_in  = '0;
        evt_ready = 1'b0;
        model_reset();
        #5;
        do_reset("por");

        // 1: reset mid-run with pending=1010 and an event presented
        step(4'b1011, 1'b0, "t1a");
        step(4'b0000, 1'b0, "t1b");
        check("t1.pre_pending", 32'(pending),   32'b1010);
        check("t1.pre_valid",   32'(evt_valid), 32'd1);
        do_reset("t1.rst");
        check("t1.pending0",  32'(pending),   32'd0);
        check("t1.valid0",    32'(evt_valid), 32'd0);
        check("t1.id0",       32'(evt_id),    32'd0);
        check("t1.overflow0", 32'(overflow),  32'd0);

        // 2: single press on button 2
        step(4'b0100, 1'b1, "t2a");
        check("t2.pending", 32'(pending),   32'b0100);
        check("t2.valid_a", 32'(evt_valid), 32'd0);
        step(4'b0000, 1'b1, "t2b");
        check("t2.valid_b", 32'(evt_valid), 32'd1);
        check("t2.id",      32'(evt_id),    32'd2);
        check("t2.pend0",   32'(pending),   32'd0);
        step(4'b0000, 1'b1, "t2c");
        check("t2.valid_c", 32'(evt_valid), 32'd0);

        // 3: round robin, twice, starting from a fresh pointer
        do_reset("t3.rst");
        for (int rep = 0; rep < 2; rep++) begin
            step(4'b1111, 1'b1, "t3p");
            for (int i = 0; i < N; i++) begin
                step(4'b0000, 1'b1, "t3s");
                check($sformatf("t3.r%0d.id%0d", rep, i), 32'(evt_id), 32'(i));
                check($sformatf("t3.r%0d.v%0d", rep, i),  32'(evt_valid), 32'd1);
            end
            step(4'b0000, 1'b1, "t3e");
            check("t3.drain", 32'(evt_valid), 32'd0);
        end

        // 4: backpressure holds event 0, then 0 and 1 are accepted in order
        do_reset("t4.rst");
        step(4'b0011, 1'b0, "t4p");
        for (int i = 0; i < 10; i++) begin
            step(4'b0000, 1'b0, "t4h");
            check("t4.hold_v",  32'(evt_valid), 32'd1);
            check("t4.hold_id", 32'(evt_id),    32'd0);
        end
        step(4'b0000, 1'b1, "t4a");
        check("t4.next_id", 32'(evt_id),    32'd1);
        check("t4.next_v",  32'(evt_valid), 32'd1);
        step(4'b0000, 1'b1, "t4b");
        check("t4.empty",   32'(evt_valid), 32'd0);

        // 5: overflow on a repeated press, then a press on the load edge
        do_reset("t5.rst");
        step(4'b0001, 1'b0, "t5a");
        step(4'b0010, 1'b0, "t5b");
        step(4'b0010, 1'b0, "t5c");
        check("t5.ovf",     32'(overflow), 32'd1);
        check("t5.pending", 32'(pending),  32'b0010);
        step(4'b0000, 1'b0, "t5d");
        check("t5.ovf_one", 32'(overflow), 32'd0);
        step(4'b0010, 1'b1, "t5e");
        check("t5.load_id", 32'(evt_id),   32'd1);
        check("t5.rearm",   32'(pending),  32'b0010);
        check("t5.no_ovf",  32'(overflow), 32'd0);

        // 6: two presses 200 ns apart give two events, in press order
        do_reset("t6.rst");
        ovf_seen = 1'b0;
        for (int c = 0; c < 30; c++) begin
            step((c == 0) ? 4'b0001 : (c == 10) ? 4'b0010 : 4'b0000, 1'b1, "t6");
            if (evt_valid) ev_q.push_back(int'(evt_id));
            if (overflow)  ovf_seen = 1'b1;
        end
        check("t6.count", 32'(ev_q.size()), 32'd2);
        check("t6.first",  (ev_q.size() > 0) ? 32'(ev_q[0]) : 32'hFFFF_FFFF, 32'd0);
        check("t6.second", (ev_q.size() > 1) ? 32'(ev_q[1]) : 32'hFFFF_FFFF, 32'd1);
        check("t6.no_ovf", 32'(ovf_seen), 32'd0);

        // Randomized run against the model, with occasional resets
        do_reset("rnd.rst");
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 199) == 0) begin
                do_reset("rnd.rst");
            end else begin
                for (int b = 0; b < N; b++) rp[b] = ($urandom_range(0, 5) == 0);
                step(rp, ($urandom_range(0, 9) < 7), "rnd");
            end
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
